// File: rtl/alu_pkg.sv
// Shared opcode constants, legality check and sequencer state encoding for the
// 4-bit ALU command path.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam int CMD_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_4bit.sv
// Purely combinational 4-bit ALU: AND, OR, ADD, SUB, SLT with signed overflow.
// SLT reports the overflow of the underlying subtraction.
module alu_4bit
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] operation,
    output logic [3:0] result,
    output logic       zero,
    output logic       overflow
);

    logic [3:0] sum;
    logic [3:0] diff;
    logic       add_ovf;
    logic       sub_ovf;

    always_comb begin
        sum      = a + b;
        diff     = a - b;
        add_ovf  = (a[3] == b[3]) && (sum[3] != a[3]);
        sub_ovf  = (a[3] != b[3]) && (diff[3] != a[3]);
        result   = 4'd0;
        overflow = 1'b0;
        case (operation)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD: begin
                result   = sum;
                overflow = add_ovf;
            end
            OP_SUB: begin
                result   = diff;
                overflow = sub_ovf;
            end
            OP_SLT: begin
                // True signed less-than: sign of the difference corrected by overflow
                result   = {3'b000, diff[3] ^ sub_ovf};
                overflow = sub_ovf;
            end
            default: ;
        endcase
    end

    assign zero = (result == 4'd0);

endmodule

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU sequencer; entries are {op, b, a}.
// Writes into a full FIFO are dropped even if a pop happens in the same cycle.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [CMD_W-1:0] push_data,
    input  logic             pop,
    output logic [CMD_W-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue/writeback stage around the combinational 4-bit ALU: buffers commands,
// registers ALU operands, captures results and presents them on valid/ready.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_op,
    input  logic [3:0]       alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_data,
    output logic             res_zero,
    output logic             res_ovf,
    output logic             res_illegal,
    output logic             ovf_sticky,
    input  logic             ovf_clear,
    output logic [CNT_W-1:0] fifo_count,
    output logic [1:0]       dbg_state
);

    // Handshakes: a command transfers on a rising edge with cmd_valid && cmd_ready;
    // a result transfers on a rising edge with res_valid && res_ready, and res_*
    // hold steady while res_valid is high and res_ready is low.

    state_t           state;
    state_t           state_d;
    logic [CMD_W-1:0] head;
    logic             full;
    logic             empty;
    logic             head_legal;
    logic             fetch;
    logic             pop;
    logic             issue;
    logic             capture;
    logic             mark_illegal;
    logic             release_res;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid),
        .push_data ({cmd_op, cmd_b, cmd_a}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    assign cmd_ready  = !full;
    assign head_legal = is_legal_op(head[10:8]);
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d      = state;
        fetch        = 1'b0;
        pop          = 1'b0;
        issue        = 1'b0;
        capture      = 1'b0;
        mark_illegal = 1'b0;
        release_res  = 1'b0;
        case (state)
            ST_IDLE: fetch = 1'b1;
            ST_EXEC: begin
                capture = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_valid && res_ready) begin
                    release_res = 1'b1;
                    state_d     = ST_IDLE;
                    fetch       = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Illegal commands skip the ALU entirely and produce a result at once
        if (fetch && !empty) begin
            pop = 1'b1;
            if (head_legal) begin
                issue   = 1'b1;
                state_d = ST_EXEC;
            end else begin
                mark_illegal = 1'b1;
                state_d      = ST_HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_zero    <= 1'b0;
            res_ovf     <= 1'b0;
            res_illegal <= 1'b0;
            ovf_sticky  <= 1'b0;
        end else begin
            if (issue) begin
                alu_a  <= head[3:0];
                alu_b  <= head[7:4];
                alu_op <= head[10:8];
            end
            if (capture) begin
                res_data    <= alu_result;
                res_zero    <= alu_zero;
                res_ovf     <= alu_overflow;
                res_illegal <= 1'b0;
                res_valid   <= 1'b1;
            end else if (mark_illegal) begin
                res_data    <= '0;
                res_zero    <= 1'b0;
                res_ovf     <= 1'b0;
                res_illegal <= 1'b1;
                res_valid   <= 1'b1;
            end else if (release_res) begin
                res_valid <= 1'b0;
            end
            // A fresh overflow beats a simultaneous clear
            if (capture && alu_overflow) begin
                ovf_sticky <= 1'b1;
            end else if (ovf_clear) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

endmodule
